// File: rtl/demux_1x4_rr_scheduler_if.sv
// Handshake bundle between the 1x4 round-robin scheduler and its environment.
// The master side drives the upstream word and downstream readies; the slave side is the scheduler.
interface demux_1x4_rr_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              en;
    logic [3:0]        chan_en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              s0;
    logic              s1;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_ready;
    logic [CNT_W-1:0]  dlv_count;

    modport master (
        output en, chan_en, in_valid, in_data, out_ready,
        input  in_ready, s0, s1, out_valid, out_data, dlv_count
    );

    modport slave (
        input  en, chan_en, in_valid, in_data, out_ready,
        output in_ready, s0, s1, out_valid, out_data, dlv_count
    );
endinterface

// File: rtl/demux_1x4_rr_scheduler.sv
// Round-robin scheduler for a 1x4 demux: holds one word and steers it to the next
// enabled channel in cyclic order, honouring per-channel ready backpressure.
//
//  state | meaning
//  EMPTY | no word held, out_valid all zero, s1/s0 keep last target
//  HOLD  | word held in out_data, presented on channel sel until that channel is ready
module demux_1x4_rr_scheduler #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    demux_1x4_rr_scheduler_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              deliver;
    logic              accept;
    logic              in_ready;
    logic [1:0]        start;
    logic [2:0]        tgt;

    // Returns {found, index} of the first enabled channel at or after start, cyclically.
    function automatic logic [2:0] find_tgt(input logic [1:0] st, input logic [3:0] mask);
        logic [2:0] r;
        logic [1:0] idx;
        r = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = st + 2'(k);
            if (mask[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        deliver  = (state_q == HOLD) && bus.out_ready[sel_q];
        start    = deliver ? (sel_q + 2'd1) : ptr_q;
        tgt      = find_tgt(start, bus.chan_en);
        in_ready = !rst && bus.en && tgt[2] && ((state_q == EMPTY) || deliver);
        accept   = bus.in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (deliver) begin
            ptr_d   = sel_q + 2'd1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = EMPTY;
        end
        if (accept) begin
            state_d = HOLD;
            data_d  = bus.in_data;
            sel_d   = tgt[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.out_data  = data_q;
    assign bus.s0        = sel_q[0];
    assign bus.s1        = sel_q[1];
    assign bus.dlv_count = cnt_q;
endmodule

// File: tb/tb_demux_1x4_rr_scheduler.sv
// Bench for the 1x4 round-robin scheduler: directed scenarios plus random traffic,
// all checked against a behavioural model of the scheduling rules.
module tb_demux_1x4_rr_scheduler;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    demux_1x4_rr_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    demux_1x4_rr_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers following the scheduling rules.
    bit        m_full;
    int        m_sel;
    int        m_ptr;
    logic [7:0] m_data;
    int        m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_tgt(input int st, input logic [3:0] mask);
        for (int k = 0; k < 4; k++)
            if (mask[(st + k) % 4]) return (st + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_onehot();
        logic [3:0] v;
        v = 4'b0000;
        if (m_full) v[m_sel] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_full = 0; m_sel = 0; m_ptr = 0; m_data = 8'h00; m_cnt = 0;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    // Entered and left at posedge+1; inputs are set by the caller before calling.
    task automatic cyc();
        bit dlv, rdy, acc;
        int st, t;
        @(negedge clk);
        dlv = m_full && bus.out_ready[m_sel];
        st  = dlv ? (m_sel + 1) % 4 : m_ptr;
        t   = m_tgt(st, bus.chan_en);
        rdy = bus.en && (t >= 0) && (!m_full || dlv);
        acc = bus.in_valid && rdy;
        chk("in_ready",  {31'b0, bus.in_ready}, {31'b0, rdy});
        chk("out_valid", {28'b0, bus.out_valid}, {28'b0, m_onehot()});
        chk("out_data",  {24'b0, bus.out_data}, {24'b0, m_data});
        chk("sel",       {30'b0, bus.s1, bus.s0}, 32'(m_sel));
        chk("dlv_count", {28'b0, bus.dlv_count}, 32'(m_cnt % 16));
        @(posedge clk);
        if (dlv) begin
            m_cnt++;
            m_ptr  = (m_sel + 1) % 4;
            m_full = 0;
        end
        if (acc) begin
            m_full = 1;
            m_data = bus.in_data;
            m_sel  = t;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", {28'b0, bus.out_valid}, 32'h0);
        chk("rst_sel",       {30'b0, bus.s1, bus.s0}, 32'h0);
        chk("rst_dlv",       {28'b0, bus.dlv_count}, 32'h0);
        chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input bit e, input logic [3:0] ce, input bit iv,
                         input logic [7:0] d, input logic [3:0] ordy);
        bus.en = e; bus.chan_en = ce; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    endtask

    int exp_ch [4];

    initial begin
        drive(1'b0, 4'h0, 1'b0, 8'h00, 4'h0);
        do_reset();

        // Round-robin over all channels, back-to-back.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'hF, 1'b1, 8'(8'h10 + i), 4'hF);
            cyc();
            chk("rr_ch", {30'b0, bus.s1, bus.s0}, 32'(i % 4));
            chk("rr_data", {24'b0, bus.out_data}, 32'(8'h10 + i));
        end
        drive(1'b1, 4'hF, 1'b0, 8'h00, 4'hF);
        cyc();
        chk("rr_count", {28'b0, bus.dlv_count}, 32'd6);

        // Async reset in the middle of a hold.
        drive(1'b1, 4'hF, 1'b1, 8'hA5, 4'h0);
        cyc();
        chk("hold_a5", {24'b0, bus.out_data}, 32'hA5);
        chk("hold_a5_v", {28'b0, bus.out_valid}, 32'b0100);
        #2;
        do_reset();

        // Skip mask 1010.
        exp_ch = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b1010, 1'b1, 8'(8'h20 + i), 4'hF);
            cyc();
            chk("skip_ch", {30'b0, bus.s1, bus.s0}, 32'(exp_ch[i]));
        end
        drive(1'b1, 4'b1010, 1'b0, 8'h00, 4'hF);
        cyc();
        drive(1'b1, 4'b0000, 1'b1, 8'h55, 4'hF);
        cyc();
        chk("nomask_rdy", {31'b0, bus.in_ready}, 32'h0);
        chk("nomask_v", {28'b0, bus.out_valid}, 32'h0);

        // Backpressure on channel 2.
        do_reset();
        drive(1'b1, 4'hF, 1'b1, 8'h01, 4'hF); cyc();
        drive(1'b1, 4'hF, 1'b1, 8'h02, 4'hF); cyc();
        drive(1'b1, 4'hF, 1'b1, 8'h3C, 4'b1011); cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'hF, 1'b1, 8'h77, 4'b1011);
            cyc();
            chk("bp_valid", {28'b0, bus.out_valid}, 32'b0100);
            chk("bp_data", {24'b0, bus.out_data}, 32'h3C);
            chk("bp_rdy", {31'b0, bus.in_ready}, 32'h0);
        end
        drive(1'b1, 4'hF, 1'b1, 8'h77, 4'hF);
        cyc();
        chk("bp_next_ch", {30'b0, bus.s1, bus.s0}, 32'd3);
        chk("bp_next_v", {28'b0, bus.out_valid}, 32'b1000);

        // Mask change while holding on channel 1.
        drive(1'b1, 4'hF, 1'b0, 8'h00, 4'hF); cyc();
        drive(1'b1, 4'b0010, 1'b1, 8'h61, 4'h0); cyc();
        chk("mask_hold_ch", {30'b0, bus.s1, bus.s0}, 32'd1);
        drive(1'b1, 4'b1101, 1'b0, 8'h00, 4'h0); cyc();
        chk("mask_hold_v", {28'b0, bus.out_valid}, 32'b0010);
        drive(1'b1, 4'b1101, 1'b1, 8'h62, 4'hF); cyc();
        chk("mask_next_ch", {30'b0, bus.s1, bus.s0}, 32'd2);

        // en=0 still lets the held word drain.
        drive(1'b1, 4'hF, 1'b0, 8'h00, 4'h0); cyc();
        drive(1'b0, 4'hF, 1'b1, 8'h99, 4'hF); cyc();
        chk("en0_drain", {28'b0, bus.out_valid}, 32'h0);
        cyc();
        chk("en0_noacc", {28'b0, bus.out_valid}, 32'h0);

        // Counter wrap after 16 deliveries.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'hF, 1'b1, 8'(i), 4'hF);
            cyc();
        end
        drive(1'b1, 4'hF, 1'b0, 8'h00, 4'hF);
        cyc();
        chk("wrap_cnt", {28'b0, bus.dlv_count}, 32'h0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 7) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  8'($urandom), 4'($urandom));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
